full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Registered N-bit full adder: adds two WIDTH-bit operands plus a 1-bit carry-in.
- Produces a WIDTH-bit sum and a carry-out one clock after a valid input.
- Leaf arithmetic cell for ripple/carry-chained adders in the datapath.
- With WIDTH=1 it is a clocked single-bit full adder, so it can be cascaded bit-by-bit with cout feeding the next cin.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  a, b, cin are valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH
- cout  output  1  registered carry-out, bit WIDTH of a + b + cin
- out_valid  output  1  sum/cout updated by the previous in_valid

Behaviour:
- One clock; reset is asynchronous and active-high (rst); all flops clear immediately on rst=1, independent of clk.
- Reset values: sum=0, cout=0, out_valid=0; further outputs under FULL_ADDER_FLAGS_EN also reset to 0.
- Arithmetic: internal WIDTH+1-bit result r = {1'b0,a} + {1'b0,b} + cin.
  - sum = r[WIDTH-1:0], cout = r[WIDTH].
  - Unsigned, no saturation, wrap modulo 2^WIDTH.
- Internal structure: explicit bit-serial ripple chain of 1-bit full-adder equations.
  - s_i = a_i ^ b_i ^ c_i
  - c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i
  - c_0 = cin
  - Result must equal r for all inputs.
- Latency: exactly 1 cycle. At a rising edge with in_valid=1, sum/cout capture the result of current a/b/cin and out_valid<=1.
- At a rising edge with in_valid=0: sum/cout hold previous values; out_valid<=0.
- Throughput: one operation per cycle; back-to-back in_valid accepted with no bubbles.
- No backpressure; outputs must be consumed in the cycle out_valid=1.
- Inputs with in_valid=0 are don't-care and must not change sum/cout.
- Reset mid-operation: an in-flight result is discarded; the first valid input after rst deasserts produces out_valid one cycle later.
- Boundary values:
  - all-zero inputs give sum=0, cout=0.
  - all-ones a and b with cin=1 give sum=all-ones, cout=1.
- No X propagation from unused inputs when in_valid=0.

Optional Feature:
- Macro FULL_ADDER_FLAGS_EN.
- When defined, adds registered outputs, updated and held under the same rules as sum/cout:
  - zero (1): sum==0
  - ovf (1): signed two's-complement overflow = c_WIDTH ^ c_(WIDTH-1)
  - prop (1): group propagate = &(a ^ b)
  - gen (1): group generate, carry-out when cin=0
- All four reset to 0.
- When not defined, these ports and their logic are absent; the port list is exactly as above.

Test Plan:
- Assert rst asynchronously mid-cycle with prior sum=7 -> sum=0, cout=0, out_valid=0 immediately, before the next clk edge.
- WIDTH=4, cin=0, consecutive valid inputs -> each result appears one cycle after its input, with out_valid=1:
  - a=0000, b=0000 -> sum=0000, cout=0
  - a=0001, b=0110 -> sum=0111, cout=0
  - a=1000, b=1001 -> sum=0001, cout=1
  - a=1111, b=1111 -> sum=1110, cout=1
- WIDTH=4, a=1111, b=1111, cin=1 -> sum=1111, cout=1. Then a=1111, b=0000, cin=1 -> sum=0000, cout=1; with flags enabled, zero=1, ovf=0.
- WIDTH=1, exhaustive 8 combinations of a, b, cin -> {cout,sum} = a+b+cin.
- Valid input, then in_valid=0 for 3 cycles with random a/b/cin -> sum/cout hold, out_valid=0 after the first cycle.
- WIDTH=8 with flags: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1, zero=0, prop=0, gen=0.

Source files
------------

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder.
// FULL_ADDER_FLAGS_EN adds the zero/ovf/prop/gen result flags to the bundle.
interface full_adder_if #(
  parameter int unsigned WIDTH = 1
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
`ifdef FULL_ADDER_FLAGS_EN
  logic             zero;
  logic             ovf;
  logic             prop;
  logic             gen;
`endif

`ifdef FULL_ADDER_FLAGS_EN
  // Operand source side
  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, out_valid, zero, ovf, prop, gen
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, out_valid, zero, ovf, prop, gen
  );
`else
  // Operand source side
  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, out_valid
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, out_valid
  );
`endif

endinterface

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-in/carry-out, 1-cycle latency.
// Optional macro FULL_ADDER_FLAGS_EN adds registered zero/ovf/prop/gen flags.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input logic        clk,
  input logic        rst,
  full_adder_if.slave bus
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH:0]   carry;
`ifdef FULL_ADDER_FLAGS_EN
  logic [WIDTH:0]   gcarry;
  logic             zero_c;
  logic             ovf_c;
  logic             prop_c;
  logic             gen_c;
`endif

  // Bit-serial ripple chain of 1-bit full-adder cells, c_0 = cin
  always_comb begin
    sum_c    = '0;
    carry    = '0;
    carry[0] = bus.cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_c[i]   = bus.a[i] ^ bus.b[i] ^ carry[i];
      carry[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & carry[i]) | (bus.b[i] & carry[i]);
    end
  end

`ifdef FULL_ADDER_FLAGS_EN
  // Flag terms; the generate chain is the same ripple with the carry-in forced to 0
  always_comb begin
    gcarry    = '0;
    gcarry[0] = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      gcarry[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & gcarry[i]) | (bus.b[i] & gcarry[i]);
    end
    zero_c = (sum_c == '0);
    ovf_c  = carry[WIDTH] ^ carry[WIDTH-1];
    prop_c = &(bus.a ^ bus.b);
    gen_c  = gcarry[WIDTH];
  end
`endif

  // Result registers: capture on in_valid, otherwise hold; out_valid tracks in_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.out_valid <= 1'b0;
`ifdef FULL_ADDER_FLAGS_EN
      bus.zero      <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.prop      <= 1'b0;
      bus.gen       <= 1'b0;
`endif
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sum  <= sum_c;
        bus.cout <= carry[WIDTH];
`ifdef FULL_ADDER_FLAGS_EN
        bus.zero <= zero_c;
        bus.ovf  <= ovf_c;
        bus.prop <= prop_c;
        bus.gen  <= gen_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=4, 1 and 8 against an arithmetic model.
module tb_full_adder;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  full_adder_if #(.WIDTH(4)) b4 ();
  full_adder_if #(.WIDTH(1)) b1 ();
  full_adder_if #(.WIDTH(8)) b8 ();

  full_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests++;
    if (b4.sum !== 4'd0 || b4.cout !== 1'b0 || b4.out_valid !== 1'b0) begin
      $display("FAIL reset_w4 got sum=%h cout=%b ov=%b want 0 0 0", b4.sum, b4.cout, b4.out_valid);
      fails++;
    end
    tests++;
    if (b1.sum !== 1'b0 || b1.cout !== 1'b0 || b1.out_valid !== 1'b0) begin
      $display("FAIL reset_w1 got sum=%h cout=%b ov=%b want 0 0 0", b1.sum, b1.cout, b1.out_valid);
      fails++;
    end
    tests++;
    if (b8.sum !== 8'd0 || b8.cout !== 1'b0 || b8.out_valid !== 1'b0) begin
      $display("FAIL reset_w8 got sum=%h cout=%b ov=%b want 0 0 0", b8.sum, b8.cout, b8.out_valid);
      fails++;
    end
`ifdef FULL_ADDER_FLAGS_EN
    tests++;
    if ({b8.zero, b8.ovf, b8.prop, b8.gen} !== 4'b0000) begin
      $display("FAIL reset_flags got %b want 0000", {b8.zero, b8.ovf, b8.prop, b8.gen});
      fails++;
    end
`endif
    #4;
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    b4.a = 4'd3; b4.b = 4'd4; b4.cin = 1'b0; b4.in_valid = 1'b1;
    tick();
    b4.in_valid = 1'b0;
    tests++;
    if (b4.sum !== 4'd7 || b4.out_valid !== 1'b1) begin
      $display("FAIL pre_reset_sum got sum=%h ov=%b want 7 1", b4.sum, b4.out_valid);
      fails++;
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (b4.sum !== 4'd0 || b4.cout !== 1'b0 || b4.out_valid !== 1'b0) begin
      $display("FAIL async_reset got sum=%h cout=%b ov=%b want 0 0 0", b4.sum, b4.cout, b4.out_valid);
      fails++;
    end
    // A valid input presented while reset is held must be discarded
    b4.a = 4'd5; b4.b = 4'd5; b4.cin = 1'b1; b4.in_valid = 1'b1;
    tick();
    rst = 1'b0;
    b4.in_valid = 1'b0;
    tick();
    tests++;
    if (b4.sum !== 4'd0 || b4.out_valid !== 1'b0) begin
      $display("FAIL reset_discard got sum=%h ov=%b want 0 0", b4.sum, b4.out_valid);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] av [4];
    logic [3:0] bv [4];
    logic [4:0] r;
    av[0] = 4'b0000; bv[0] = 4'b0000;
    av[1] = 4'b0001; bv[1] = 4'b0110;
    av[2] = 4'b1000; bv[2] = 4'b1001;
    av[3] = 4'b1111; bv[3] = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      b4.a = av[i]; b4.b = bv[i]; b4.cin = 1'b0; b4.in_valid = 1'b1;
      r = 5'(av[i]) + 5'(bv[i]);
      tick();
      tests++;
      if (b4.sum !== r[3:0] || b4.cout !== r[4] || b4.out_valid !== 1'b1) begin
        $display("FAIL b2b[%0d] got sum=%b cout=%b ov=%b want %b %b 1", i, b4.sum, b4.cout, b4.out_valid, r[3:0], r[4]);
        fails++;
      end
    end
    b4.in_valid = 1'b0;
  endtask

  task automatic test_carry_in();
    logic [3:0] av [2];
    logic [3:0] bv [2];
    logic [4:0] r;
    int         sv;
    av[0] = 4'b1111; bv[0] = 4'b1111;
    av[1] = 4'b1111; bv[1] = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      b4.a = av[i]; b4.b = bv[i]; b4.cin = 1'b1; b4.in_valid = 1'b1;
      r  = 5'(av[i]) + 5'(bv[i]) + 5'd1;
      sv = int'($signed(av[i])) + int'($signed(bv[i])) + 1;
      tick();
      tests++;
      if (b4.sum !== r[3:0] || b4.cout !== r[4] || b4.out_valid !== 1'b1) begin
        $display("FAIL cin[%0d] got sum=%b cout=%b ov=%b want %b %b 1", i, b4.sum, b4.cout, b4.out_valid, r[3:0], r[4]);
        fails++;
      end
`ifdef FULL_ADDER_FLAGS_EN
      tests++;
      if (b4.zero !== (r[3:0] == 4'd0) || b4.ovf !== (sv > 7 || sv < -8)) begin
        $display("FAIL cin_flags[%0d] got zero=%b ovf=%b want %b %b", i, b4.zero, b4.ovf, (r[3:0] == 4'd0), (sv > 7 || sv < -8));
        fails++;
      end
`endif
    end
    b4.in_valid = 1'b0;
  endtask

  task automatic test_w1_exhaustive();
    logic [1:0] r;
    logic [2:0] k3;
    for (int k = 0; k < 8; k++) begin
      k3 = 3'(k);
      b1.a = k3[2]; b1.b = k3[1]; b1.cin = k3[0]; b1.in_valid = 1'b1;
      r = 2'(k3[2]) + 2'(k3[1]) + 2'(k3[0]);
      tick();
      tests++;
      if ({b1.cout, b1.sum} !== r || b1.out_valid !== 1'b1) begin
        $display("FAIL w1[%0d] got {cout,sum}=%b ov=%b want %b 1", k, {b1.cout, b1.sum}, b1.out_valid, r);
        fails++;
      end
    end
    b1.in_valid = 1'b0;
  endtask

  task automatic test_hold();
    logic [4:0] r;
    b4.a = 4'($urandom); b4.b = 4'($urandom); b4.cin = 1'($urandom); b4.in_valid = 1'b1;
    r = 5'(b4.a) + 5'(b4.b) + 5'(b4.cin);
    tick();
    tests++;
    if (b4.sum !== r[3:0] || b4.cout !== r[4] || b4.out_valid !== 1'b1) begin
      $display("FAIL hold_load got sum=%b cout=%b ov=%b want %b %b 1", b4.sum, b4.cout, b4.out_valid, r[3:0], r[4]);
      fails++;
    end
    b4.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b4.a = 4'($urandom); b4.b = 4'($urandom); b4.cin = 1'($urandom);
      tick();
      tests++;
      if (b4.sum !== r[3:0] || b4.cout !== r[4] || b4.out_valid !== 1'b0) begin
        $display("FAIL hold[%0d] got sum=%b cout=%b ov=%b want %b %b 0", i, b4.sum, b4.cout, b4.out_valid, r[3:0], r[4]);
        fails++;
      end
    end
  endtask

  task automatic test_w8_flags();
    b8.a = 8'h7F; b8.b = 8'h01; b8.cin = 1'b0; b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    tests++;
    if (b8.sum !== 8'h80 || b8.cout !== 1'b0 || b8.out_valid !== 1'b1) begin
      $display("FAIL w8_7f got sum=%h cout=%b ov=%b want 80 0 1", b8.sum, b8.cout, b8.out_valid);
      fails++;
    end
`ifdef FULL_ADDER_FLAGS_EN
    tests++;
    if ({b8.ovf, b8.zero, b8.prop, b8.gen} !== 4'b1000) begin
      $display("FAIL w8_flags got ovf,zero,prop,gen=%b want 1000", {b8.ovf, b8.zero, b8.prop, b8.gen});
      fails++;
    end
`endif
  endtask

  task automatic test_random();
    logic [8:0] r;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ov;
`ifdef FULL_ADDER_FLAGS_EN
    logic [3:0] exp_flags;
    int         sv;
    exp_flags = {b8.zero, b8.ovf, b8.prop, b8.gen};
`endif
    exp_sum  = b8.sum;
    exp_cout = b8.cout;
    for (int i = 0; i < 200; i++) begin
      b8.in_valid = ($urandom_range(0, 9) < 7);
      b8.a = 8'($urandom); b8.b = 8'($urandom); b8.cin = 1'($urandom);
      if (($urandom_range(0, 7)) == 0) begin
        b8.a = 8'hFF; b8.b = 8'hFF - 8'($urandom_range(0, 1));
      end
      exp_ov = b8.in_valid;
      if (b8.in_valid) begin
        r        = 9'(b8.a) + 9'(b8.b) + 9'(b8.cin);
        exp_sum  = r[7:0];
        exp_cout = r[8];
`ifdef FULL_ADDER_FLAGS_EN
        sv = int'($signed(b8.a)) + int'($signed(b8.b)) + int'(b8.cin);
        exp_flags = {r[7:0] == 8'd0, sv > 127 || sv < -128, (b8.a ^ b8.b) == 8'hFF,
                     (9'(b8.a) + 9'(b8.b)) > 9'd255};
`endif
      end
      tick();
      tests++;
      if (b8.sum !== exp_sum || b8.cout !== exp_cout || b8.out_valid !== exp_ov) begin
        $display("FAIL rand[%0d] got sum=%h cout=%b ov=%b want %h %b %b", i, b8.sum, b8.cout, b8.out_valid, exp_sum, exp_cout, exp_ov);
        fails++;
      end
`ifdef FULL_ADDER_FLAGS_EN
      tests++;
      if ({b8.zero, b8.ovf, b8.prop, b8.gen} !== exp_flags) begin
        $display("FAIL rand_flags[%0d] got %b want %b", i, {b8.zero, b8.ovf, b8.prop, b8.gen}, exp_flags);
        fails++;
      end
`endif
    end
    b8.in_valid = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    b4.in_valid = 1'b0; b4.a = '0; b4.b = '0; b4.cin = 1'b0;
    b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0;
    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
    test_reset();
    test_async_reset();
    test_back_to_back();
    test_carry_in();
    test_w1_exhaustive();
    test_hold();
    test_w8_flags();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
